if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_id.sv | 34 +++
 rtl/if_stage.sv | 65 ++++++
 tb/tb_if_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: bus widths, control encodings, reset vector.
// No logic; imported by if_stage and if_id.
package if_stage_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] ResetVector = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] PcStep      = 32'd4;
    localparam logic [InstAddrBus-1:0] AlignMask   = 32'hFFFF_FFFC;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;

    // Fetch addresses are word aligned; low two bits of any redirect are dropped.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return addr & AlignMask;
    endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register: one cycle from fetch to decode, flush/bubble clear the pair.
// Backpressure: holds while IF and ID are both stalled; bubble when only IF stalls.
module if_id
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall_if,
    input  logic                   stall_id,
    input  logic [InstAddrBus-1:0] if_pc,
    input  logic [InstBus-1:0]     if_inst,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            id_pc   <= ZeroWord;
            id_inst <= ZeroWord;
        end else if (flush) begin
            id_pc   <= ZeroWord;
            id_inst <= ZeroWord;
        end else if (stall_if == Stop && stall_id == NoStop) begin
            // IF stalled but ID moving on: feed it a NOP rather than a duplicate.
            id_pc   <= ZeroWord;
            id_inst <= ZeroWord;
        end else if (stall_if == NoStop) begin
            id_pc   <= if_pc;
            id_inst <= if_inst;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC/chip-enable generation plus the IF/ID register; 1-cycle fetch-to-ID.
// Backpressure: stall[0] freezes the PC, stall[2:1] drive hold/bubble in if_id; flush overrides.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc,
    output logic        ce,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    logic [InstBus-1:0] fetched_inst;
    logic               stall_unused;

    assign stall_unused = ^stall[5:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            ce <= ChipDisable;
        end else begin
            ce <= ChipEnable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc <= ResetVector;
        end else if (ce == ChipDisable) begin
            // First enabled cycle still presents the reset vector.
            pc <= ResetVector;
        end else if (flush) begin
            pc <= word_align(new_pc);
        end else if (stall[0] == Stop) begin
            pc <= pc;
        end else if (branch_flag_i == Branch) begin
            pc <= word_align(branch_target_address_i);
        end else begin
            pc <= pc + PcStep;
        end
    end

    // Memory output is meaningless while disabled; capture a NOP instead.
    assign fetched_inst = (ce == ChipEnable) ? inst_i : ZeroWord;

    if_id u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall_if (stall[1]),
        .stall_id (stall[2]),
        .if_pc    (pc),
        .if_inst  (fetched_inst),
        .id_pc    (id_pc),
        .id_inst  (id_inst)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory modelled as inst = addr ^ 0xDEAD0000.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_i                  (inst_i),
        .pc                      (pc),
        .ce                      (ce),
        .id_pc                   (id_pc),
        .id_inst                 (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inst_i = pc ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'b0;
        flush = 1'b0;
        new_pc = 32'h0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;

        // Reset / boot
        repeat (3) step();
        chk("rst_ce", {31'b0, ce}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        rst = 1'b0;
        step();
        chk("boot_ce", {31'b0, ce}, 32'h1);
        chk("boot_pc0", pc, 32'h0);
        chk("boot_id_inst0", id_inst, 32'h0);
        step();
        chk("boot_pc4", pc, 32'h4);
        chk("boot_id_pc0", id_pc, 32'h0);
        chk("boot_id_inst_a", id_inst, 32'hDEAD_0000);
        step();
        chk("boot_pc8", pc, 32'h8);
        chk("boot_id_pc4", id_pc, 32'h4);
        chk("boot_id_inst_b", id_inst, 32'hDEAD_0004);

        // Branch at pc=0x10 with misaligned target
        step();
        step();
        chk("pre_br_pc", pc, 32'h10);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h0000_0103;
        step();
        chk("br_pc", pc, 32'h100);
        chk("br_id_pc", id_pc, 32'h10);
        chk("br_id_inst", id_inst, 32'hDEAD_0010);
        branch_flag_i = 1'b0;
        step();
        chk("br_next_pc", pc, 32'h104);
        chk("br_next_id_pc", id_pc, 32'h100);

        // Stall: steer to 0x1C, advance to 0x20
        flush = 1'b1;
        new_pc = 32'h1C;
        step();
        chk("fl_pc", pc, 32'h1C);
        chk("fl_id_pc", id_pc, 32'h0);
        chk("fl_id_inst", id_inst, 32'h0);
        flush = 1'b0;
        step();
        chk("st_pre_pc", pc, 32'h20);
        stall = 6'b000111;
        step();
        chk("st1_pc", pc, 32'h20);
        chk("st1_id_pc", id_pc, 32'h1C);
        chk("st1_id_inst", id_inst, 32'hDEAD_001C);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        step();
        chk("st2_pc_br_ignored", pc, 32'h20);
        chk("st2_id_pc", id_pc, 32'h1C);
        chk("st2_id_inst", id_inst, 32'hDEAD_001C);
        branch_flag_i = 1'b0;
        stall = 6'b000011;
        step();
        chk("bub_pc", pc, 32'h20);
        chk("bub_id_pc", id_pc, 32'h0);
        chk("bub_id_inst", id_inst, 32'h0);
        stall = 6'b0;
        step();
        chk("unst_pc", pc, 32'h24);
        chk("unst_id_pc", id_pc, 32'h20);
        chk("unst_id_inst", id_inst, 32'hDEAD_0020);

        // Flush beats stall and branch; low bits dropped
        stall = 6'b000111;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h500;
        flush = 1'b1;
        new_pc = 32'h0000_0383;
        step();
        chk("flp_pc", pc, 32'h380);
        chk("flp_id_pc", id_pc, 32'h0);
        chk("flp_id_inst", id_inst, 32'h0);
        stall = 6'b0;
        branch_flag_i = 1'b0;

        // Wrap at top of address space
        new_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        flush = 1'b0;
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_inst", id_inst, 32'h2152_FFFC);
        step();
        chk("wrap_next_pc", pc, 32'h4);

        // Async reset between edges, with stall/flush active
        #2;
        stall = 6'b000111;
        flush = 1'b1;
        new_pc = 32'h380;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_ce", {31'b0, ce}, 32'h0);
        chk("arst_id_pc", id_pc, 32'h0);
        chk("arst_id_inst", id_inst, 32'h0);
        step();
        chk("arst_hold_pc", pc, 32'h0);
        chk("arst_hold_ce", {31'b0, ce}, 32'h0);
        rst = 1'b0;
        stall = 6'b0;
        flush = 1'b0;
        step();
        chk("rb_ce", {31'b0, ce}, 32'h1);
        chk("rb_pc0", pc, 32'h0);
        step();
        chk("rb_pc4", pc, 32'h4);
        chk("rb_id_inst", id_inst, 32'hDEAD_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
